// File: rtl/am2940_pkg.sv
// am2940_pkg: shared constants for the parametrised Am2940 DMA address generator.
//   - 3-bit instruction codes decoded by the top level
//   - control-register mode codes (CR[1:0])
//   - bit positions of the direction and halt-on-done control bits
package am2940_pkg;

    localparam logic [2:0] INSTR_WRCR   = 3'b000;
    localparam logic [2:0] INSTR_RDCR   = 3'b001;
    localparam logic [2:0] INSTR_RDWC   = 3'b010;
    localparam logic [2:0] INSTR_RDAC   = 3'b011;
    localparam logic [2:0] INSTR_REINIT = 3'b100;
    localparam logic [2:0] INSTR_LDAR   = 3'b101;
    localparam logic [2:0] INSTR_LDWC   = 3'b110;
    localparam logic [2:0] INSTR_ENCT   = 3'b111;

    localparam logic [1:0] MODE_WC_DOWN  = 2'd0;
    localparam logic [1:0] MODE_WC_UP    = 2'd1;
    localparam logic [1:0] MODE_ADDR_CMP = 2'd2;
    localparam logic [1:0] MODE_WC_ZERO  = 2'd3;

    localparam int CR_DIR_BIT  = 2;
    localparam int CR_HALT_BIT = 3;

endpackage

// File: rtl/am2940_counter.sv
// am2940_counter: loadable WIDTH-bit up/down counter with ripple carries.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   load_i/load_val_i parallel load (has priority over counting)
//   en_i              count enable; the counter steps only when cin_n_i is also low
//   down_i            1 = count down, 0 = count up
//   cin_n_i           active-low carry-in
//   q_o               counter value
//   cout_n_o          active-low carry-out: low when carry-in is low and q_o is
//                     at the terminal value for the current direction
module am2940_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    input  logic             down_i,
    input  logic             cin_n_i,
    output logic [WIDTH-1:0] q_o,
    output logic             cout_n_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             terminal_s;

    // Next-count selection: load beats counting; counting wraps modulo 2^WIDTH.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && !cin_n_i) begin
            cnt_d = down_i ? (cnt_q - ONE) : (cnt_q + ONE);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Carry-out does not depend on en_i so cascaded slices see it early.
    always_comb begin
        terminal_s = down_i ? (cnt_q == '0) : (cnt_q == '1);
        cout_n_o   = ~(~cin_n_i & terminal_s);
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/am2940_dma_gen.sv
// am2940_dma_gen: parametrised-width Am2940-style DMA address generator.
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset
//   instr       3-bit instruction, sampled every cycle
//   data_in     load data for CR / AR+AC / WR+WC writes
//   data_out    combinational read of CR, WC or AC (0 for other instructions)
//   addr_out    address counter AC
//   acineg      active-low address carry-in;  aconeg active-low carry-out
//   wcineg      active-low word carry-in;     wconeg active-low carry-out
//   done        combinational transfer-complete flag
// Build option: define AM2940_AUTO_REINIT_EN to make ENCT perform REINIT on the
// cycle done is high (halt-on-done clear), producing repeated blocks.
module am2940_dma_gen
    import am2940_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       instr,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] addr_out,
    input  logic             acineg,
    output logic             aconeg,
    input  logic             wcineg,
    output logic             wconeg,
    output logic             done
);

    logic [3:0]       cr_q, cr_d;
    logic [WIDTH-1:0] ar_q, ar_d;
    logic [WIDTH-1:0] wr_q, wr_d;
    logic [WIDTH-1:0] ac_s, wc_s;
    logic [1:0]       mode_s;
    logic             halted_s, auto_s, cnt_en_s;
    logic             ac_load_s, wc_load_s, wc_en_s, wc_down_s, wc_cout_n_s;
    logic [WIDTH-1:0] ac_load_val_s, wc_load_val_s;

    // Control decode: done flag, halt, and load/count steering for both counters.
    always_comb begin
        mode_s = cr_q[1:0];
        case (mode_s)
            MODE_WC_DOWN:  done = (wc_s == {{(WIDTH-1){1'b0}}, 1'b1});
            MODE_WC_UP:    done = (wc_s == wr_q);
            MODE_ADDR_CMP: done = (ac_s == wr_q);
            MODE_WC_ZERO:  done = (wc_s == '0);
            default:       done = 1'b0;
        endcase
        halted_s = cr_q[CR_HALT_BIT] & done;
`ifdef AM2940_AUTO_REINIT_EN
        auto_s = (instr == INSTR_ENCT) & done & ~cr_q[CR_HALT_BIT];
`else
        auto_s = 1'b0;
`endif
        cnt_en_s      = (instr == INSTR_ENCT) & ~halted_s & ~auto_s;
        ac_load_s     = (instr == INSTR_LDAR) | (instr == INSTR_REINIT) | auto_s;
        ac_load_val_s = (instr == INSTR_LDAR) ? data_in : ar_q;
        wc_load_s     = (instr == INSTR_LDWC) | (instr == INSTR_REINIT) | auto_s;
        // Mode 1 counts WC up from zero towards WR, so every WC load clears it.
        if (mode_s == MODE_WC_UP) begin
            wc_load_val_s = '0;
        end else if (instr == INSTR_LDWC) begin
            wc_load_val_s = data_in;
        end else begin
            wc_load_val_s = wr_q;
        end
        wc_en_s   = cnt_en_s & (mode_s != MODE_ADDR_CMP);
        wc_down_s = (mode_s != MODE_WC_UP);
        wconeg    = ((mode_s == MODE_ADDR_CMP) || halted_s) ? 1'b1 : wc_cout_n_s;
    end

    // Register writes for CR, AR and WR.
    always_comb begin
        cr_d = cr_q;
        ar_d = ar_q;
        wr_d = wr_q;
        case (instr)
            INSTR_WRCR: cr_d = data_in[3:0];
            INSTR_LDAR: ar_d = data_in;
            INSTR_LDWC: wr_d = data_in;
            default: begin
                cr_d = cr_q;
                ar_d = ar_q;
                wr_d = wr_q;
            end
        endcase
    end

    // Combinational read-back path.
    always_comb begin
        data_out = '0;
        case (instr)
            INSTR_RDCR: data_out[3:0] = cr_q;
            INSTR_RDWC: data_out = wc_s;
            INSTR_RDAC: data_out = ac_s;
            default:    data_out = '0;
        endcase
    end

    // Control, address and word register state.
    always_ff @(posedge clk) begin
        if (reset) begin
            cr_q <= 4'h0;
            ar_q <= '0;
            wr_q <= '0;
        end else begin
            cr_q <= cr_d;
            ar_q <= ar_d;
            wr_q <= wr_d;
        end
    end

    am2940_counter #(.WIDTH(WIDTH)) u_ac (
        .clk        (clk),
        .reset      (reset),
        .load_i     (ac_load_s),
        .load_val_i (ac_load_val_s),
        .en_i       (cnt_en_s),
        .down_i     (cr_q[CR_DIR_BIT]),
        .cin_n_i    (acineg),
        .q_o        (ac_s),
        .cout_n_o   (aconeg)
    );

    am2940_counter #(.WIDTH(WIDTH)) u_wc (
        .clk        (clk),
        .reset      (reset),
        .load_i     (wc_load_s),
        .load_val_i (wc_load_val_s),
        .en_i       (wc_en_s),
        .down_i     (wc_down_s),
        .cin_n_i    (wcineg),
        .q_o        (wc_s),
        .cout_n_o   (wc_cout_n_s)
    );

    assign addr_out = ac_s;

endmodule

// File: tb/tb_am2940_dma_gen.sv
// tb_am2940_dma_gen: directed self-checking bench for am2940_dma_gen (WIDTH=8).
module tb_am2940_dma_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] instr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [7:0] addr_out;
    logic       acineg, aconeg, wcineg, wconeg, done;
    int         errors = 0;
    int         checks = 0;

    localparam logic [2:0] WRCR = 3'b000, RDCR = 3'b001, RDWC = 3'b010, RDAC = 3'b011;
    localparam logic [2:0] REINIT = 3'b100, LDAR = 3'b101, LDWC = 3'b110, ENCT = 3'b111;

    am2940_dma_gen #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .instr(instr), .data_in(data_in),
        .data_out(data_out), .addr_out(addr_out), .acineg(acineg),
        .aconeg(aconeg), .wcineg(wcineg), .wconeg(wconeg), .done(done)
    );

    always #5 clk = ~clk;

    // Apply one instruction across one rising edge; outputs settle 1 time unit later.
    task automatic step(input logic [2:0] op, input logic [7:0] d);
        instr   = op;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        acineg = 1'b1; wcineg = 1'b1;
        step(WRCR, 8'h0F); step(LDAR, 8'hA5); step(LDWC, 8'h3C);
        // Reset asserted alongside a load: reset must win.
        reset = 1'b1;
        step(LDAR, 8'h55);
        reset = 1'b0;
        instr = ENCT; #1;
        checks++; if (addr_out !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want %h", addr_out, 8'h00); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (aconeg !== 1'b1 || wconeg !== 1'b1) begin errors++; $display("FAIL reset_carry: got %b%b want 11", aconeg, wconeg); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_dout_enct: got %h want 00", data_out); end
        instr = RDCR; #1;
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_rdcr: got %h want 00", data_out); end
        instr = RDWC; #1;
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_rdwc: got %h want 00", data_out); end
        instr = RDAC; #1;
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_rdac: got %h want 00", data_out); end
    endtask

    task automatic test_mode2_inc();
        step(WRCR, 8'h02); step(LDAR, 8'h01); step(LDWC, 8'h04);
        acineg = 1'b0; wcineg = 1'b0;
        checks++; if (addr_out !== 8'h01) begin errors++; $display("FAIL m2_start: got %h want 01", addr_out); end
        step(ENCT, 8'h00);
        checks++; if (addr_out !== 8'h02) begin errors++; $display("FAIL m2_ac2: got %h want 02", addr_out); end
        checks++; if (wconeg !== 1'b1) begin errors++; $display("FAIL m2_wconeg: got %b want 1", wconeg); end
        step(ENCT, 8'h00);
        checks++; if (addr_out !== 8'h03 || done !== 1'b0) begin errors++; $display("FAIL m2_ac3: got %h/%b want 03/0", addr_out, done); end
        step(ENCT, 8'h00);
        checks++; if (addr_out !== 8'h04 || done !== 1'b1) begin errors++; $display("FAIL m2_done: got %h/%b want 04/1", addr_out, done); end
        step(ENCT, 8'h00);
`ifdef AM2940_AUTO_REINIT_EN
        checks++; if (addr_out !== 8'h01) begin errors++; $display("FAIL m2_after: got %h want 01", addr_out); end
`else
        checks++; if (addr_out !== 8'h05 || done !== 1'b0) begin errors++; $display("FAIL m2_after: got %h/%b want 05/0", addr_out, done); end
`endif
    endtask

    task automatic test_mode0_halt();
        step(WRCR, 8'h00); step(LDAR, 8'h10); step(LDWC, 8'h03);
        instr = RDWC; #1;
        checks++; if (data_out !== 8'h03) begin errors++; $display("FAIL m0_wc3: got %h want 03", data_out); end
        step(ENCT, 8'h00);
        checks++; if (addr_out !== 8'h11 || done !== 1'b0) begin errors++; $display("FAIL m0_step1: got %h/%b want 11/0", addr_out, done); end
        step(ENCT, 8'h00);
        checks++; if (addr_out !== 8'h12 || done !== 1'b1) begin errors++; $display("FAIL m0_done: got %h/%b want 12/1", addr_out, done); end
        step(WRCR, 8'h08);
        step(ENCT, 8'h00);
        checks++; if (addr_out !== 8'h12 || done !== 1'b1) begin errors++; $display("FAIL m0_halt_ac: got %h/%b want 12/1", addr_out, done); end
        checks++; if (wconeg !== 1'b1) begin errors++; $display("FAIL m0_halt_wconeg: got %b want 1", wconeg); end
        instr = RDWC; #1;
        checks++; if (data_out !== 8'h01) begin errors++; $display("FAIL m0_halt_wc: got %h want 01", data_out); end
    endtask

    task automatic test_decrement_carry();
        step(WRCR, 8'h04); step(LDWC, 8'h50); step(LDAR, 8'h01);
        checks++; if (aconeg !== 1'b1) begin errors++; $display("FAIL dec_aconeg_1: got %b want 1", aconeg); end
        step(ENCT, 8'h00);
        checks++; if (addr_out !== 8'h00 || aconeg !== 1'b0) begin errors++; $display("FAIL dec_zero: got %h/%b want 00/0", addr_out, aconeg); end
        acineg = 1'b1; #1;
        checks++; if (aconeg !== 1'b1) begin errors++; $display("FAIL dec_cin_high: got %b want 1", aconeg); end
        step(ENCT, 8'h00);
        checks++; if (addr_out !== 8'h00) begin errors++; $display("FAIL dec_frozen: got %h want 00", addr_out); end
        acineg = 1'b0;
        step(ENCT, 8'h00);
        checks++; if (addr_out !== 8'hFF || aconeg !== 1'b1) begin errors++; $display("FAIL dec_wrap: got %h/%b want FF/1", addr_out, aconeg); end
        instr = RDAC; #1;
        checks++; if (data_out !== 8'hFF) begin errors++; $display("FAIL dec_rdac: got %h want FF", data_out); end
    endtask

    task automatic test_mode1_up();
        step(WRCR, 8'h01); step(LDWC, 8'h03);
        instr = RDWC; #1;
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL m1_wc_zero: got %h want 00", data_out); end
        instr = RDCR; #1;
        checks++; if (data_out !== 8'h01) begin errors++; $display("FAIL m1_rdcr: got %h want 01", data_out); end
        step(LDAR, 8'h30);
        step(ENCT, 8'h00); step(ENCT, 8'h00);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL m1_not_done: got %b want 0", done); end
        step(ENCT, 8'h00);
        checks++; if (done !== 1'b1 || addr_out !== 8'h33) begin errors++; $display("FAIL m1_done: got %b/%h want 1/33", done, addr_out); end
        instr = RDWC; #1;
        checks++; if (data_out !== 8'h03) begin errors++; $display("FAIL m1_wc3: got %h want 03", data_out); end
        step(REINIT, 8'h00);
        checks++; if (addr_out !== 8'h30) begin errors++; $display("FAIL m1_reinit_ac: got %h want 30", addr_out); end
        instr = RDWC; #1;
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL m1_reinit_wc: got %h want 00", data_out); end
    endtask

    task automatic test_mode3_carry();
        step(WRCR, 8'h03); step(LDWC, 8'h01);
        checks++; if (done !== 1'b0 || wconeg !== 1'b1) begin errors++; $display("FAIL m3_start: got %b/%b want 0/1", done, wconeg); end
        step(ENCT, 8'h00);
        checks++; if (done !== 1'b1 || wconeg !== 1'b0) begin errors++; $display("FAIL m3_zero: got %b/%b want 1/0", done, wconeg); end
    endtask

`ifdef AM2940_AUTO_REINIT_EN
    task automatic test_auto_reinit();
        step(WRCR, 8'h00); step(LDAR, 8'h20); step(LDWC, 8'h02);
        for (int r = 0; r < 3; r++) begin
            checks++; if (addr_out !== 8'h20 || done !== 1'b0) begin errors++; $display("FAIL auto_base%0d: got %h/%b want 20/0", r, addr_out, done); end
            step(ENCT, 8'h00);
            checks++; if (addr_out !== 8'h21 || done !== 1'b1) begin errors++; $display("FAIL auto_next%0d: got %h/%b want 21/1", r, addr_out, done); end
            step(ENCT, 8'h00);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; instr = RDCR; data_in = 8'h00; acineg = 1'b1; wcineg = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_mode2_inc();
        test_mode0_halt();
        test_decrement_carry();
        test_mode1_up();
        test_mode3_carry();
`ifdef AM2940_AUTO_REINIT_EN
        test_auto_reinit();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/am2940_dma_gen.md
Name: am2940_dma_gen

Overview:
Parametrised-width successor of the 8-bit Am2940 DMA address generator, built for wide buses and cascaded slices.
- Keeps the 3-bit instruction set, the four control modes, the ripple carries and the DONE output.
- Adds synchronous reset, a programmable address direction and halt-on-done.
- Optional: auto-reinitialise on DONE, for chained block transfers.
- Sits between the microsequencer (instr, data_in) and the memory address bus (addr_out).

Parameters:
WIDTH, 8, width of the data bus, the address/word registers and the counters (minimum 4).

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high; clears all registers on the next rising edge.
instr  input  3  instruction code, sampled every cycle.
data_in  input  WIDTH  load data for control, address and word-count writes.
data_out  output  WIDTH  read data.
addr_out  output  WIDTH  current address counter (AC).
acineg  input  1  address carry-in, active low; AC counts only when low.
aconeg  output  1  address carry-out, active low.
wcineg  input  1  word carry-in, active low; WC counts only when low.
wconeg  output  1  word carry-out, active low.
done  output  1  transfer-complete flag.

Behaviour:
Registers:
- CR (4 bits): [1:0] mode, [2] direction (0 = increment AC, 1 = decrement), [3] halt-on-done.
- AR address reg, AC address counter, WR word reg, WC word counter; each WIDTH bits.

Reset:
- CR, AR, AC, WR and WC all become 0.
- Immediately after reset: addr_out=0, data_out=0, aconeg=1, wconeg=1, done=0.
- Reset asserted mid-transfer overrides any instruction in the same cycle.

Instructions (effect at the next clk edge; reads are combinational):
- 000 WRCR: CR <= data_in[3:0].
- 001 RDCR: data_out = {0, CR}.
- 010 RDWC: data_out = WC.
- 011 RDAC: data_out = AC.
- 100 REINIT: AC <= AR; WC <= WR, except WC <= 0 in mode 1.
- 101 LDAR: AR <= data_in and AC <= data_in.
- 110 LDWC: WR <= data_in; WC <= data_in, except WC <= 0 in mode 1.
- 111 ENCT: enable counting.
- data_out = 0 for any instruction other than 001/010/011.

Counting under ENCT:
- AC steps by ±1 (per CR[2]) when acineg=0.
- WC steps when wcineg=0: down in modes 0 and 3, up in mode 1, held in mode 2.
- All counters wrap modulo 2^WIDTH.

DONE, combinational:
- mode 0: WC==1.
- mode 1: WC==WR.
- mode 2: AC==WR.
- mode 3: WC==0.

Halt: if CR[3]=1 and done=1, ENCT leaves AC and WC unchanged.

Carry-outs:
- aconeg=0 iff acineg=0 and AC is at its terminal value (all-ones when incrementing, zero when decrementing).
- wconeg=0 iff wcineg=0 and WC is at its terminal value for its current count direction.
- In mode 2, and whenever halted, wconeg=1.

Optional Feature:
AM2940_AUTO_REINIT_EN
- Defined: ENCT in a cycle where done=1 and CR[3]=0 performs REINIT instead of counting (AC<=AR, WC<=WR or 0), giving continuous repeated blocks. done stays combinational.
- Undefined: counters step or wrap normally.

Decomposition:
- am2940_pkg: instruction codes (INSTR_WRCR..INSTR_ENCT), mode codes (MODE_WC_DOWN, MODE_WC_UP, MODE_ADDR_CMP, MODE_WC_ZERO), CR bit indices.
- Sub-module am2940_counter (WIDTH param): loadable up/down counter with enable, active-low carry-in/out. Instantiated twice, for AC and WC.

Test Plan:
1. reset=1 for one edge after arbitrary loads -> addr_out=0, RDCR/RDWC/RDAC all read 0, done=0.
2. Mode 2, increment: WRCR 0x02, LDAR 1, LDWC 4, ENCT with carries low -> addr_out 1,2,3,4 on successive edges; done=1 when AC=4, then AC=5 next edge.
3. Mode 0: WRCR 0x00, LDAR 0x10, LDWC 3, ENCT -> WC 3,2,1, AC 0x10,0x11,0x12; done=1 at WC=1. With CR=0x08 (halt), AC holds at 0x12.
4. Decrement plus carry: WRCR 0x04, LDAR 0x01, ENCT -> AC 0x01, 0x00 (aconeg=0 while AC=0), 0xFF; acineg=1 -> AC frozen, aconeg=1.
5. Mode 1: WRCR 0x01, LDWC 3 -> RDWC reads 0; ENCT three edges -> WC 1,2,3, done=1 at 3; REINIT -> WC=0, AC=AR.
6. AM2940_AUTO_REINIT_EN defined, mode 0, AR=0x20, WR=2 -> AC 0x20,0x21, then 0x20 again on the done cycle; repeats indefinitely.
